router_sync_n: RTL
==================

Name: router_sync_n

Overview:
Parametrised successor of the 1x3 router synchroniser. It latches the destination address of each incoming packet and steers the register block's write strobe to one of NUM_CH output FIFOs. It muxes the selected FIFO's full flag back to the router FSM, drives per-channel valid-out, and issues per-channel soft resets when a destination stops reading. Sits between router_fsm/router_reg and the NUM_CH router_fifo instances. Adds over the fixed 3-channel block:
- channel count and timeout are parameters
- illegal-address detection with an error flag
- watchdog re-arm after each soft-reset pulse

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, width of address field in header; must satisfy 2**ADDR_W >= NUM_CH
TIMEOUT, 30, consecutive idle-valid cycles before soft reset (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  synchronous active-low reset
data_in  in  ADDR_W  address field of header byte
detect_add  in  1  FSM strobe: header present, latch data_in
write_enb_reg  in  1  FSM strobe: write current byte to selected FIFO
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
read_enb  in  NUM_CH  per-FIFO read enables from destinations
write_enb  out  NUM_CH  one-hot FIFO write enable
fifo_full  out  1  full flag of selected FIFO
vld_out  out  NUM_CH  data-valid to destinations
soft_reset  out  NUM_CH  one-cycle FIFO flush pulse per channel
addr_err  out  1  latched address is out of range

Behaviour:
- Reset (resetn=0 at rising edge): addr_reg=0, addr_vld=0, addr_err=0, all timer counters=0, soft_reset=0. Combinational outputs follow from cleared state: write_enb=0, fifo_full=0. vld_out stays combinational on empty during reset.
- Address latch: at an edge with detect_add=1, addr_reg<=data_in. At the same edge, addr_vld<=(data_in<NUM_CH) and addr_err<=(data_in>=NUM_CH). Without detect_add, addr_reg, addr_vld and addr_err hold.
- detect_add and write_enb_reg high in the same cycle: write_enb uses the previously latched addr_reg; the new address applies from the next cycle.
- write_enb (combinational, zero latency): bit addr_reg=1 iff write_enb_reg && addr_vld; all other bits 0. Never more than one bit high. An invalid address gives all zeros, so the packet is dropped.
- fifo_full (combinational) = addr_vld ? full[addr_reg] : 0. It tracks changes on the selected full bit in the same cycle.
- vld_out[i] = ~empty[i] (combinational).
- Watchdog, per channel i, counter width $clog2(TIMEOUT):
  - idle[i] = vld_out[i] && !read_enb[i]
  - !idle[i] → counter<=0, soft_reset[i]<=0
  - idle[i] && counter==TIMEOUT-1 → soft_reset[i]<=1 (exactly one cycle), counter<=0
  - otherwise idle → counter+1, soft_reset[i]<=0
  - soft_reset[i] therefore rises at the edge ending the TIMEOUT-th consecutive idle cycle.
  - If the channel stays idle after the pulse, the next pulse follows TIMEOUT cycles later.
  - A read_enb in any cycle restarts the count.
- Channels are fully independent; simultaneous timeouts on several channels pulse together.
- Mid-operation reset clears counters; soft_reset drops at that edge.
- No wrap-around beyond TIMEOUT-1: the counter is cleared on the pulse.

Decomposition:
- Shared package router_pkg holds:
  - ROUTER_NUM_CH_DEF=3
  - ROUTER_TIMEOUT_DEF=30
  - a clog2-based ADDR_W/counter-width function
- Sub-module router_sync_timer (params TIMEOUT; ports clk, resetn, vld, rd, soft_reset), instantiated NUM_CH times via generate.

Test Plan:
- resetn=0 one cycle with empty=3'b000 → write_enb=0, fifo_full=0, soft_reset=0, addr_err=0; vld_out=3'b111.
- detect_add=1, data_in=2'b01; next cycle write_enb_reg=1 → write_enb=3'b010. With full=3'b010 → fifo_full=1; with full=3'b101 → fifo_full=0.
- detect_add with data_in=2'b11 (NUM_CH=3) → addr_err=1 next cycle, write_enb=0 under write_enb_reg=1, fifo_full=0. A later detect_add with 2'b10 → addr_err=0, write_enb=3'b100.
- empty[1]=0, read_enb[1]=0 for 30 cycles → soft_reset=3'b010 for exactly one cycle after the 30th edge. Holding idle gives a second pulse 30 cycles later.
- empty[2]=0, read_enb[2] pulsed at idle cycle 29 → no soft_reset. Then 30 further idle cycles → pulse.
- Channels 0 and 2 idle from the same cycle → simultaneous soft_reset=3'b101. resetn=0 at idle cycle 15 → no pulse until 30 idle cycles after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared defaults and sizing helper for the parametrised router synchroniser.
// The helper sizes the watchdog counters and address fields.
package router_pkg;

  localparam int ROUTER_NUM_CH_DEF  = 3;
  localparam int ROUTER_TIMEOUT_DEF = 30;

  // Ceiling log2 with a floor of one bit, so tiny values still give a usable width.
  function automatic int routerClog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel watchdog: flushes a FIFO when its destination leaves valid data
// unread for TIMEOUT consecutive cycles, then re-arms for another window.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int CNT_W = routerClog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             idle;

  assign idle = vld && !rd;

  // The count restarts on the pulse itself, so a stalled channel re-fires every TIMEOUT cycles.
  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (idle) begin
      if (cnt_q == CNT_LAST) begin
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser for NUM_CH output FIFOs: latches the header address,
// steers the write strobe, returns the selected full flag and runs the watchdogs.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH_DEF,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_vld_q, addr_vld_d;
  logic              addr_err_q, addr_err_d;
  logic              in_range;

  assign in_range = ({1'b0, data_in} < (ADDR_W + 1)'(NUM_CH));

  always_comb begin
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      addr_d     = data_in;
      addr_vld_d = in_range;
      addr_err_d = !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Decoding against each channel index keeps out-of-range addresses from ever selecting a FIFO.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out  = ~empty;
  assign addr_err = addr_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .rd        (read_enb[g]),
      .soft_reset(soft_reset[g])
    );
  end

endmodule
